usb_gamepad_link_supervisor: RTL and testbench
==============================================

// Module: usb_gamepad_link_supervisor
// PURPOSE
//  Sequences the low-speed USB HID host behind the gamepad reader: holds the host in bus reset, waits for
//  reports, detects a stalled or unplugged pad, and re-resets the host with exponential backoff.
//  Latches decoded buttons once per video frame so software sees frame-coherent state plus per-frame
//  press edges. Sits between the HID host/report decoder and the CPU-visible gamepad registers.
// PARAMETERS
//  RESET_CYCLES    16      cycles host_reset is held after reset release or after a timeout (>=1)
//  ATTACH_TIMEOUT  6000000 cycles to wait for first report after a host reset, before backoff (>=1)
//  ACTIVE_TIMEOUT  1200000 consecutive report-less cycles in ACTIVE that declare link lost (>=1)
//  BACKOFF_MAX     3       max backoff exponent; attach window = ATTACH_TIMEOUT << backoff
// PORTS
//  clk              in   1   system clock (same domain as HID host)
//  reset            in   1   synchronous, active-high
//  report_valid     in   1   1-cycle strobe: decoded report on btn_in is valid
//  btn_in           in   12  decoded buttons from report decoder
//  frame_strobe     in   1   1-cycle strobe per video frame (vblank start)
//  host_reset       out  1   drives HID host bus_reset
//  connected        out  1   1 while state == ACTIVE
//  btn_out          out  12  frame-latched buttons
//  btn_pressed      out  12  buttons newly pressed at last frame_strobe
//  reconnect_count  out  8   count of ACTIVE->RESET_HOLD drops, saturating at 255
// BEHAVIOUR
//  Reset (clk edge with reset=1): state=RESET_HOLD, timer=0, backoff=0, sample=0; host_reset=1,
//   connected=0, btn_out=0, btn_pressed=0, reconnect_count=0. Applies from any state, mid-operation too.
//  All outputs registered. Timer width = $clog2((ATTACH_TIMEOUT<<BACKOFF_MAX)+1); no truncation allowed.
//  FSM:
//   RESET_HOLD: host_reset=1; after RESET_CYCLES cycles in state -> WAIT_FIRST (host_reset=0 from then).
//     report_valid ignored.
//   WAIT_FIRST: report_valid -> ACTIVE, sample<=btn_in, backoff<=0, timer cleared.
//     (ATTACH_TIMEOUT<<backoff) cycles with no report -> RESET_HOLD, backoff<=min(backoff+1,BACKOFF_MAX).
//   ACTIVE: report_valid -> sample<=btn_in, timer cleared. ACTIVE_TIMEOUT consecutive cycles without
//     report_valid -> RESET_HOLD, sample<=0, reconnect_count+1 (saturating), backoff unchanged (0).
//  State-entry outputs: host_reset/connected reflect new state on the clock edge that enters it.
//  Simultaneous report_valid and timeout expiry: report wins; no transition.
//  Frame latch: on frame_strobe, btn_out<=sample (value before this edge) and
//   btn_pressed<=sample & ~btn_out; else both hold. report_valid+frame_strobe together: btn_out gets
//   old sample, new sample appears on next frame.
//  Disconnect: sample cleared on leaving ACTIVE, so btn_out goes 0 at next frame_strobe; btn_pressed
//   never reports edges from a dead link.
//  btn_in bit mapping passed through unchanged.
// TESTING (RESET_CYCLES=4, ATTACH_TIMEOUT=16, ACTIVE_TIMEOUT=8, BACKOFF_MAX=2)
//  1. Release reset, no reports -> host_reset high exactly 4 cycles, then low; connected stays 0.
//  2. No reports ever -> WAIT_FIRST windows 16, 32, 64, 64 cycles, each followed by 4-cycle host_reset.
//  3. report_valid with btn_in=12'h021 in WAIT_FIRST -> connected=1 next edge; frame_strobe ->
//     btn_out=12'h021, btn_pressed=12'h021; second frame_strobe, same input -> btn_pressed=12'h000.
//  4. Reports every 8 cycles -> stays ACTIVE indefinitely; one gap of 9 -> host_reset=1,
//     reconnect_count=1, connected=0; next frame_strobe -> btn_out=0.
//  5. report_valid on the cycle the ACTIVE timer would expire -> remains ACTIVE, count unchanged;
//     report_valid together with frame_strobe -> btn_out shows previous sample.
//  6. Assert reset while ACTIVE with btn_out=12'hFFF, reconnect_count=3 -> all outputs to reset
//     values next edge, 4-cycle host_reset after release; 256 drops -> reconnect_count holds 255.

Source files
------------

// File: rtl/usb_gamepad_link_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : usb_gamepad_link_supervisor
// Brief    : HID host link sequencing with backoff, plus frame-coherent buttons
// Revision : 1.0
// ============================================================================
module usb_gamepad_link_supervisor #(
    parameter int RESET_CYCLES   = 16,
    parameter int ATTACH_TIMEOUT = 6000000,
    parameter int ACTIVE_TIMEOUT = 1200000,
    parameter int BACKOFF_MAX    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        report_valid,
    input  logic [11:0] btn_in,
    input  logic        frame_strobe,
    output logic        host_reset,
    output logic        connected,
    output logic [11:0] btn_out,
    output logic [11:0] btn_pressed,
    output logic [7:0]  reconnect_count
);

    localparam logic [63:0] C_MAX_WINDOW = 64'(ATTACH_TIMEOUT) << BACKOFF_MAX;
    localparam int C_TW_ATT = $clog2(C_MAX_WINDOW + 64'd1);
    localparam int C_TW_ACT = $clog2(ACTIVE_TIMEOUT + 1);
    localparam int C_TW_RST = $clog2(RESET_CYCLES + 1);
    localparam int C_TW_AR  = (C_TW_ACT > C_TW_RST) ? C_TW_ACT : C_TW_RST;
    localparam int C_TW     = (C_TW_ATT > C_TW_AR) ? C_TW_ATT : C_TW_AR;
    localparam int C_BW     = (BACKOFF_MAX > 0) ? $clog2(BACKOFF_MAX + 1) : 1;

    localparam logic [C_TW-1:0] C_TIMER_ONE  = C_TW'(1);
    localparam logic [C_TW-1:0] C_RESET_LAST = C_TW'(RESET_CYCLES - 1);
    localparam logic [C_TW-1:0] C_ACT_LAST   = C_TW'(ACTIVE_TIMEOUT - 1);
    localparam logic [C_BW-1:0] C_BO_MAX     = C_BW'(BACKOFF_MAX);
    localparam logic [C_BW-1:0] C_BO_ONE     = C_BW'(1);

    typedef enum logic [1:0] {
        S_RESET_HOLD = 2'd0,
        S_WAIT_FIRST = 2'd1,
        S_ACTIVE     = 2'd2
    } state_t;

    state_t          r_state;
    logic [C_TW-1:0] r_timer;
    logic [C_BW-1:0] r_backoff;
    logic [11:0]     r_sample;
    logic [C_TW-1:0] w_attach_last;

    // The attach window doubles with each consecutive failed attach.
    assign w_attach_last = (C_TW'(ATTACH_TIMEOUT) << r_backoff) - C_TIMER_ONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_RESET_HOLD;
            r_timer         <= '0;
            r_backoff       <= '0;
            r_sample        <= '0;
            host_reset      <= 1'b1;
            connected       <= 1'b0;
            btn_out         <= '0;
            btn_pressed     <= '0;
            reconnect_count <= '0;
        end else begin
            if (frame_strobe) begin
                btn_out     <= r_sample;
                btn_pressed <= r_sample & ~btn_out;
            end
            case (r_state)
                S_RESET_HOLD: begin
                    if (r_timer == C_RESET_LAST) begin
                        r_state    <= S_WAIT_FIRST;
                        r_timer    <= '0;
                        host_reset <= 1'b0;
                    end else begin
                        r_timer <= r_timer + C_TIMER_ONE;
                    end
                end
                S_WAIT_FIRST: begin
                    if (report_valid) begin
                        r_state   <= S_ACTIVE;
                        r_sample  <= btn_in;
                        r_backoff <= '0;
                        r_timer   <= '0;
                        connected <= 1'b1;
                    end else if (r_timer == w_attach_last) begin
                        r_state    <= S_RESET_HOLD;
                        r_timer    <= '0;
                        host_reset <= 1'b1;
                        if (r_backoff != C_BO_MAX) begin
                            r_backoff <= r_backoff + C_BO_ONE;
                        end
                    end else begin
                        r_timer <= r_timer + C_TIMER_ONE;
                    end
                end
                S_ACTIVE: begin
                    if (report_valid) begin
                        r_sample <= btn_in;
                        r_timer  <= '0;
                    end else if (r_timer == C_ACT_LAST) begin
                        // Clearing the sample keeps a dead link from producing press edges.
                        r_state    <= S_RESET_HOLD;
                        r_timer    <= '0;
                        r_sample   <= '0;
                        host_reset <= 1'b1;
                        connected  <= 1'b0;
                        if (reconnect_count != 8'hFF) begin
                            reconnect_count <= reconnect_count + 8'd1;
                        end
                    end else begin
                        r_timer <= r_timer + C_TIMER_ONE;
                    end
                end
                default: begin
                    r_state    <= S_RESET_HOLD;
                    r_timer    <= '0;
                    host_reset <= 1'b1;
                    connected  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_gamepad_link_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_gamepad_link_supervisor
// Brief    : Directed bench with a countdown-based link model checked per cycle
// Revision : 1.0
// ============================================================================
module tb_usb_gamepad_link_supervisor;

    localparam int RC  = 4;
    localparam int ATT = 16;
    localparam int ACT = 8;
    localparam int BMX = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        report_valid = 1'b0;
    logic [11:0] btn_in = '0;
    logic        frame_strobe = 1'b0;
    logic        host_reset;
    logic        connected;
    logic [11:0] btn_out;
    logic [11:0] btn_pressed;
    logic [7:0]  reconnect_count;

    int checks = 0;
    int failures = 0;

    usb_gamepad_link_supervisor #(
        .RESET_CYCLES(RC), .ATTACH_TIMEOUT(ATT), .ACTIVE_TIMEOUT(ACT), .BACKOFF_MAX(BMX)
    ) dut (
        .clk(clk), .reset(reset), .report_valid(report_valid), .btn_in(btn_in),
        .frame_strobe(frame_strobe), .host_reset(host_reset), .connected(connected),
        .btn_out(btn_out), .btn_pressed(btn_pressed), .reconnect_count(reconnect_count)
    );

    always #5 clk = ~clk;

    // Link model: phase 0 = host held in reset, 1 = awaiting attach, 2 = linked.
    // m_left counts down the cycles remaining before the current phase times out.
    bit          m_valid = 1'b0;
    int          m_phase, m_left, m_bo, m_drops;
    logic [11:0] m_sample, m_out, m_pressed;

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1; m_phase = 0; m_left = RC; m_bo = 0; m_drops = 0;
            m_sample = '0; m_out = '0; m_pressed = '0;
        end else if (m_valid) begin
            if (frame_strobe) begin
                m_pressed = m_sample & ~m_out;
                m_out     = m_sample;
            end
            if (m_phase == 0) begin
                m_left--;
                if (m_left == 0) begin m_phase = 1; m_left = ATT << m_bo; end
            end else if (m_phase == 1) begin
                if (report_valid) begin
                    m_phase = 2; m_left = ACT; m_sample = btn_in; m_bo = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 0; m_left = RC; m_bo = (m_bo < BMX) ? m_bo + 1 : BMX;
                    end
                end
            end else begin
                if (report_valid) begin
                    m_sample = btn_in; m_left = ACT;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 0; m_left = RC; m_sample = '0;
                        m_drops = (m_drops < 255) ? m_drops + 1 : 255;
                    end
                end
            end
        end
        #1;
        if (m_valid) begin
            checks++;
            if (host_reset !== (m_phase == 0) || connected !== (m_phase == 2) ||
                btn_out !== m_out || btn_pressed !== m_pressed ||
                reconnect_count !== 8'(m_drops)) begin
                failures++;
                $display("FAIL model t=%0t actual hr=%b con=%b out=%h prs=%h cnt=%0d required hr=%b con=%b out=%h prs=%h cnt=%0d",
                         $time, host_reset, connected, btn_out, btn_pressed, reconnect_count,
                         (m_phase == 0), (m_phase == 2), m_out, m_pressed, m_drops);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_report(input logic [11:0] b, input logic with_frame);
        report_valid = 1'b1; btn_in = b; frame_strobe = with_frame;
        step();
        report_valid = 1'b0; frame_strobe = 1'b0;
    endtask

    task automatic frame();
        frame_strobe = 1'b1;
        step();
        frame_strobe = 1'b0;
    endtask

    task automatic chk(input string name, input int actual, input int required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    // Number of clock edges until host_reset changes to the opposite of lvl (bounded).
    task automatic run_length(input logic lvl, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (host_reset === lvl && n < 200);
    endtask

    int n;
    int windows[4] = '{16, 32, 64, 64};

    initial begin
        idle(2);
        chk("reset_host_reset", int'(host_reset), 1);
        chk("reset_connected", int'(connected), 0);
        reset = 1'b0;

        run_length(1'b1, n);
        chk("hold_after_release", n, RC);
        for (int w = 0; w < 4; w++) begin
            run_length(1'b0, n);
            chk($sformatf("attach_window_%0d", w), n, windows[w]);
            run_length(1'b1, n);
            chk($sformatf("hold_after_window_%0d", w), n, RC);
        end

        send_report(12'h021, 1'b0);
        chk("connected_after_report", int'(connected), 1);
        frame();
        chk("frame1_btn_out", int'(btn_out), 12'h021);
        chk("frame1_pressed", int'(btn_pressed), 12'h021);
        frame();
        chk("frame2_pressed", int'(btn_pressed), 0);

        idle(5);
        send_report(12'h021, 1'b0);
        for (int k = 0; k < 4; k++) begin
            idle(7);
            send_report(12'h021, 1'b0);
        end
        chk("still_active", int'(connected), 1);
        idle(8);
        chk("drop_host_reset", int'(host_reset), 1);
        chk("drop_connected", int'(connected), 0);
        chk("drop_count", int'(reconnect_count), 1);
        frame();
        chk("drop_btn_out", int'(btn_out), 0);

        idle(4);
        send_report(12'h0F0, 1'b0);
        idle(7);
        send_report(12'h0F0, 1'b0);
        chk("edge_report_active", int'(connected), 1);
        chk("edge_report_count", int'(reconnect_count), 1);
        send_report(12'h300, 1'b1);
        chk("coincident_btn_out", int'(btn_out), 12'h0F0);
        frame();
        chk("next_frame_btn_out", int'(btn_out), 12'h300);
        chk("next_frame_pressed", int'(btn_pressed), 12'h300);

        for (int k = 0; k < 2; k++) begin
            idle(8);
            idle(4);
            send_report(12'hFFF, 1'b0);
        end
        frame();
        chk("pre_reset_btn_out", int'(btn_out), 12'hFFF);
        chk("pre_reset_count", int'(reconnect_count), 3);
        reset = 1'b1;
        step();
        chk("midrun_reset_outputs",
            {20'd0, host_reset, connected, btn_out == 12'd0, btn_pressed == 12'd0,
             reconnect_count}, {20'd0, 4'b1011, 8'd0});
        reset = 1'b0;
        run_length(1'b1, n);
        chk("hold_after_midrun_reset", n, RC);

        for (int k = 0; k < 256; k++) begin
            send_report(12'h001, 1'b0);
            idle(8);
            idle(4);
        end
        chk("count_saturates", int'(reconnect_count), 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
